reg_dato_win: RTL and testbench

Parametrised successor of the single 8-bit data register. Stores the last DEPTH samples in a circular window. Outputs the newest sample, the oldest sample, an exact running sum and a power-of-two average. It sits between the sample-capture logic and the heart-rate calculation, and smooths beat-interval or ADC data without a separate adder tree.

---
 rtl/reg_dato_win.sv | 119 +++++++++++
 tb/tb_reg_dato_win.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dato_win.sv
// Sliding-window sample register: keeps the last DEPTH samples, reports newest/oldest, exact sum and 2^n average.
// Latency: 1 cycle from a load (or clear) edge to every output; all outputs are registered.
// Backpressure: none; a load is accepted on every cycle enable=1, so the producer is never stalled.
//
// Ports:
//   clk, rst (sync, active-low)   clear (sync window flush)   enable / data_in (sample load)
//   data_out (newest)  oldest_out  sum_out  avg_out (sum_out >> LOG2D)  count  full  avg_valid (pulse)
module reg_dato_win #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int LOG2D = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       data_out,
    output logic [WIDTH-1:0]       oldest_out,
    output logic [WIDTH+LOG2D-1:0] sum_out,
    output logic [WIDTH-1:0]       avg_out,
    output logic [LOG2D:0]         count,
    output logic                   full,
    output logic                   avg_valid
);

    localparam int SW = WIDTH + LOG2D;
    localparam logic [LOG2D:0] DEPTH_CNT = (LOG2D + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2D-1:0] wr_ptr;

    logic [LOG2D-1:0] ptr_nxt;
    logic [SW-1:0]    din_ext;
    logic [SW-1:0]    evict_ext;
    logic [SW-1:0]    sum_nxt;
    logic [LOG2D:0]   cnt_nxt;
    logic             full_nxt;
    logic [WIDTH-1:0] oldest_nxt;

    // Next state for a plain load (enable=1, clear=0).
    always_comb begin
        din_ext   = SW'(data_in);
        evict_ext = SW'(mem[wr_ptr]);
        ptr_nxt   = wr_ptr + LOG2D'(1);
        sum_nxt   = sum_out + din_ext;
        cnt_nxt   = count + (LOG2D + 1)'(1);
        if (full) begin
            // Modular arithmetic at SW bits: the intermediate may wrap but the
            // final value is the true window sum, which always fits.
            sum_nxt = sum_out + din_ext - evict_ext;
            cnt_nxt = count;
        end
        full_nxt = (cnt_nxt == DEPTH_CNT);
        // While filling, wr_ptr equals count, so entry 0 is the oldest; it is
        // the incoming sample itself when this is the first load.
        // Once full, the oldest is the next slot to be overwritten, which is
        // never the slot being written now because DEPTH >= 2.
        if (full_nxt) begin
            oldest_nxt = mem[ptr_nxt];
        end else if (wr_ptr == '0) begin
            oldest_nxt = data_in;
        end else begin
            oldest_nxt = mem[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            data_out   <= '0;
            oldest_out <= '0;
            sum_out    <= '0;
            avg_out    <= '0;
            count      <= '0;
            full       <= 1'b0;
            avg_valid  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            avg_valid <= 1'b0;
            full      <= 1'b0;
            if (enable) begin
                // Flush then take data_in as the first entry of a fresh window.
                mem[0]     <= data_in;
                wr_ptr     <= LOG2D'(1);
                data_out   <= data_in;
                oldest_out <= data_in;
                sum_out    <= din_ext;
                avg_out    <= din_ext[SW-1:LOG2D];
                count      <= (LOG2D + 1)'(1);
            end else begin
                wr_ptr     <= '0;
                data_out   <= '0;
                oldest_out <= '0;
                sum_out    <= '0;
                avg_out    <= '0;
                count      <= '0;
            end
        end else if (enable) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= ptr_nxt;
            data_out    <= data_in;
            oldest_out  <= oldest_nxt;
            sum_out     <= sum_nxt;
            avg_out     <= sum_nxt[SW-1:LOG2D];
            count       <= cnt_nxt;
            full        <= full_nxt;
            avg_valid   <= full_nxt;
        end else begin
            avg_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_dato_win.sv
// Directed bench for reg_dato_win at WIDTH=8, DEPTH=8.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives loads on chosen cycles.
module tb_reg_dato_win;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        enable;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [7:0]  oldest_out;
    logic [10:0] sum_out;
    logic [7:0]  avg_out;
    logic [3:0]  count;
    logic        full;
    logic        avg_valid;

    int vectors     = 0;
    int miscompares = 0;
    int sb[$];          // last 8 loaded samples, oldest first
    int last_val;

    reg_dato_win #(.WIDTH(8), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .enable     (enable),
        .data_in    (data_in),
        .data_out   (data_out),
        .oldest_out (oldest_out),
        .sum_out    (sum_out),
        .avg_out    (avg_out),
        .count      (count),
        .full       (full),
        .avg_valid  (avg_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int sb_sum();
        int s = 0;
        foreach (sb[j]) s += sb[j];
        return s;
    endfunction

    task automatic test_reset;
        rst = 1'b0; clear = 1'b0; enable = 1'b1; data_in = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            tick;
            vectors++;
            if ({data_out, oldest_out, sum_out, avg_out, count, full, avg_valid} !== 45'd0) begin
                miscompares++;
                $display("FAIL reset_hold[%0d]: got d=%0d o=%0d s=%0d a=%0d c=%0d f=%0d v=%0d, required all 0",
                         i, data_out, oldest_out, sum_out, avg_out, count, full, avg_valid);
            end
        end
        rst = 1'b1; enable = 1'b0;
        tick;
        vectors++;
        if ({data_out, oldest_out, sum_out, avg_out, count, full, avg_valid} !== 45'd0) begin
            miscompares++;
            $display("FAIL reset_release: got d=%0d o=%0d s=%0d a=%0d c=%0d f=%0d v=%0d, required all 0",
                     data_out, oldest_out, sum_out, avg_out, count, full, avg_valid);
        end
    endtask

    task automatic test_fill;
        sb.delete();
        for (int i = 1; i <= 8; i++) begin
            data_in = 8'(i * 10); enable = 1'b1;
            sb.push_back(i * 10);
            tick;
            vectors++;
            if (count !== 4'(i) || data_out !== 8'(i * 10) || oldest_out !== 8'd10
                || full !== (i == 8) || avg_valid !== (i == 8) || sum_out !== 11'(sb_sum())) begin
                miscompares++;
                $display("FAIL fill[%0d]: got c=%0d d=%0d o=%0d f=%0d v=%0d s=%0d, required c=%0d d=%0d o=10 f=%0d v=%0d s=%0d",
                         i, count, data_out, oldest_out, full, avg_valid, sum_out,
                         i, i * 10, i == 8, i == 8, sb_sum());
            end
        end
        vectors++;
        if (sum_out !== 11'd360 || avg_out !== 8'd45) begin
            miscompares++;
            $display("FAIL fill_sum_avg: got s=%0d a=%0d, required s=360 a=45", sum_out, avg_out);
        end
        enable = 1'b0;
        tick;
        vectors++;
        if (avg_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_pulse_once: got avg_valid=%0d, required 0", avg_valid);
        end
    endtask

    task automatic test_wrap;
        data_in = 8'd90; enable = 1'b1;
        sb.push_back(90); void'(sb.pop_front());
        tick;
        vectors++;
        if (sum_out !== 11'd440 || avg_out !== 8'd55 || oldest_out !== 8'd20 || count !== 4'd8
            || avg_valid !== 1'b1 || data_out !== 8'd90) begin
            miscompares++;
            $display("FAIL wrap_90: got s=%0d a=%0d o=%0d c=%0d v=%0d d=%0d, required s=440 a=55 o=20 c=8 v=1 d=90",
                     sum_out, avg_out, oldest_out, count, avg_valid, data_out);
        end
        for (int k = 0; k < 10; k++) begin
            data_in = 8'(17 * k + 3);
            sb.push_back(17 * k + 3); void'(sb.pop_front());
            last_val = 17 * k + 3;
            tick;
            vectors++;
            if (sum_out !== 11'(sb_sum()) || avg_out !== 8'(sb_sum() >> 3) || oldest_out !== 8'(sb[0])
                || data_out !== 8'(last_val) || avg_valid !== 1'b1 || count !== 4'd8) begin
                miscompares++;
                $display("FAIL wrap_stream[%0d]: got s=%0d a=%0d o=%0d d=%0d v=%0d c=%0d, required s=%0d a=%0d o=%0d d=%0d v=1 c=8",
                         k, sum_out, avg_out, oldest_out, data_out, avg_valid, count,
                         sb_sum(), sb_sum() >> 3, sb[0], last_val);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_hold_gaps;
        for (int r = 0; r < 2; r++) begin
            enable = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick;
                vectors++;
                if (sum_out !== 11'(sb_sum()) || oldest_out !== 8'(sb[0]) || data_out !== 8'(last_val)
                    || count !== 4'd8 || avg_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL hold[%0d.%0d]: got s=%0d o=%0d d=%0d c=%0d v=%0d, required s=%0d o=%0d d=%0d c=8 v=0",
                             r, i, sum_out, oldest_out, data_out, count, avg_valid, sb_sum(), sb[0], last_val);
                end
            end
            last_val = 200 + r;
            data_in = 8'(last_val); enable = 1'b1;
            sb.push_back(last_val); void'(sb.pop_front());
            tick;
            enable = 1'b0;
            vectors++;
            if (avg_valid !== 1'b1 || sum_out !== 11'(sb_sum()) || oldest_out !== 8'(sb[0])) begin
                miscompares++;
                $display("FAIL gap_load[%0d]: got v=%0d s=%0d o=%0d, required v=1 s=%0d o=%0d",
                         r, avg_valid, sum_out, oldest_out, sb_sum(), sb[0]);
            end
        end
    endtask

    task automatic test_clear_enable;
        clear = 1'b1; enable = 1'b1; data_in = 8'd7;
        tick;
        clear = 1'b0; enable = 1'b0;
        vectors++;
        if (count !== 4'd1 || sum_out !== 11'd7 || data_out !== 8'd7 || oldest_out !== 8'd7
            || full !== 1'b0 || avg_valid !== 1'b0 || avg_out !== 8'd0) begin
            miscompares++;
            $display("FAIL clear_enable: got c=%0d s=%0d d=%0d o=%0d f=%0d v=%0d a=%0d, required c=1 s=7 d=7 o=7 f=0 v=0 a=0",
                     count, sum_out, data_out, oldest_out, full, avg_valid, avg_out);
        end
        enable = 1'b1; data_in = 8'd9;
        tick;
        enable = 1'b0;
        vectors++;
        if (count !== 4'd2 || sum_out !== 11'd16 || data_out !== 8'd9 || oldest_out !== 8'd7) begin
            miscompares++;
            $display("FAIL after_clear_load: got c=%0d s=%0d d=%0d o=%0d, required c=2 s=16 d=9 o=7",
                     count, sum_out, data_out, oldest_out);
        end
        clear = 1'b1;
        tick;
        clear = 1'b0;
        vectors++;
        if ({data_out, oldest_out, sum_out, avg_out, count, full, avg_valid} !== 45'd0) begin
            miscompares++;
            $display("FAIL clear_only: got d=%0d o=%0d s=%0d a=%0d c=%0d f=%0d v=%0d, required all 0",
                     data_out, oldest_out, sum_out, avg_out, count, full, avg_valid);
        end
    endtask

    task automatic test_extremes_reset;
        enable = 1'b1; data_in = 8'd255;
        for (int i = 0; i < 8; i++) tick;
        vectors++;
        if (sum_out !== 11'd2040 || avg_out !== 8'd255 || full !== 1'b1 || avg_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL extremes: got s=%0d a=%0d f=%0d v=%0d, required s=2040 a=255 f=1 v=1",
                     sum_out, avg_out, full, avg_valid);
        end
        for (int i = 1; i <= 4; i++) begin
            data_in = 8'(i);
            tick;
        end
        vectors++;
        if (sum_out !== 11'd1030 || oldest_out !== 8'd255 || avg_out !== 8'd128) begin
            miscompares++;
            $display("FAIL mixed_evict: got s=%0d o=%0d a=%0d, required s=1030 o=255 a=128", sum_out, oldest_out, avg_out);
        end
        rst = 1'b0; enable = 1'b0;
        tick;
        vectors++;
        if ({data_out, oldest_out, sum_out, avg_out, count, full, avg_valid} !== 45'd0) begin
            miscompares++;
            $display("FAIL midstream_reset: got d=%0d o=%0d s=%0d a=%0d c=%0d f=%0d v=%0d, required all 0",
                     data_out, oldest_out, sum_out, avg_out, count, full, avg_valid);
        end
        rst = 1'b1; enable = 1'b1; data_in = 8'd5;
        tick;
        vectors++;
        if (count !== 4'd1 || sum_out !== 11'd5 || data_out !== 8'd5 || oldest_out !== 8'd5
            || full !== 1'b0 || avg_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL first_after_reset: got c=%0d s=%0d d=%0d o=%0d f=%0d v=%0d, required c=1 s=5 d=5 o=5 f=0 v=0",
                     count, sum_out, data_out, oldest_out, full, avg_valid);
        end
        for (int i = 1; i <= 7; i++) begin
            data_in = 8'(i);
            tick;
        end
        enable = 1'b0;
        vectors++;
        if (count !== 4'd8 || sum_out !== 11'd33 || avg_out !== 8'd4 || oldest_out !== 8'd5 || avg_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL refill_after_reset: got c=%0d s=%0d a=%0d o=%0d v=%0d, required c=8 s=33 a=4 o=5 v=1",
                     count, sum_out, avg_out, oldest_out, avg_valid);
        end
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; enable = 1'b0; data_in = 8'd0; last_val = 0;
        test_reset;
        test_fill;
        test_wrap;
        test_hold_gaps;
        test_clear_enable;
        test_extremes_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
